// File: rtl/prbs_check_pkg.sv
// Shared constants for the PRBS7 word checker: widths, LFSR taps and FSM states.
package prbs_check_pkg;

    localparam int WORD_W     = 32;
    localparam int COUNT_W    = 16;
    localparam int HIST_W     = 7;
    localparam int PRBS_TAP_A = 7;
    localparam int PRBS_TAP_B = 6;

    typedef logic [0:0] state_t;
    localparam state_t ST_UNLOCKED = 1'b0;
    localparam state_t ST_LOCKED   = 1'b1;

endpackage

// File: rtl/prbs7_predict.sv
// Combinational PRBS7 predictor: expands the last 7 received bits into the
// next 32-bit word, MSB first in time.
module prbs7_predict
    import prbs_check_pkg::*;
(
    input  logic [HIST_W-1:0] hist_i,
    output logic [WORD_W-1:0] pred_o
);

    // seq[0] is the oldest history bit; seq[HIST_W] is the first predicted bit.
    logic [HIST_W+WORD_W-1:0] seq;

    always_comb begin
        seq    = '0;
        pred_o = '0;
        for (int i = 0; i < HIST_W; i++) begin
            seq[i] = hist_i[HIST_W-1-i];
        end
        for (int i = HIST_W; i < HIST_W + WORD_W; i++) begin
            seq[i] = seq[i-PRBS_TAP_A] ^ seq[i-PRBS_TAP_B];
        end
        for (int i = 0; i < WORD_W; i++) begin
            pred_o[WORD_W-1-i] = seq[HIST_W+i];
        end
    end

endmodule

// File: rtl/prbs7_word_checker.sv
// Self-synchronising PRBS7 word checker with lock FSM and error pulse output.
// Optional saturating error counter enabled by defining PRBS_ERR_COUNTER_EN.
module prbs7_word_checker
    import prbs_check_pkg::*;
#(
    parameter int LOCK_THRESHOLD   = 8,
    parameter int UNLOCK_THRESHOLD = 4
) (
    input  logic                clk40,
    input  logic                RSTn,
    input  logic [WORD_W-1:0]   din,
    input  logic                dinValid,
    input  logic                clearCount,
    output logic                error,
    output logic                locked,
    output logic [COUNT_W-1:0]  errorCount
);

    localparam int RUN_W  = $clog2(LOCK_THRESHOLD + 1);
    localparam int MISS_W = $clog2(UNLOCK_THRESHOLD + 1);

    state_t              state_q, state_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic                hist_vld_q, hist_vld_d;
    logic                error_q, error_d;

    logic [WORD_W-1:0]   pred;
    logic                word_match;
    logic [RUN_W-1:0]    run_inc;
    logic [MISS_W-1:0]   miss_inc;

    prbs7_predict u_predict (
        .hist_i (hist_q),
        .pred_o (pred)
    );

    // An all-zero history predicts all-zero data; treat that lock-up case as a mismatch.
    assign word_match = (din == pred) && (hist_q != '0);
    assign run_inc    = run_q + RUN_W'(1);
    assign miss_inc   = miss_q + MISS_W'(1);

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        miss_d     = miss_q;
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        error_d    = 1'b0;
        if (dinValid) begin
            hist_d     = din[HIST_W-1:0];
            hist_vld_d = 1'b1;
            if (hist_vld_q) begin
                if (state_q == ST_UNLOCKED) begin
                    if (!word_match) begin
                        run_d = '0;
                    end else if (run_inc == RUN_W'(LOCK_THRESHOLD)) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end else begin
                    if (word_match) begin
                        miss_d = '0;
                    end else begin
                        error_d = 1'b1;
                        if (miss_inc == MISS_W'(UNLOCK_THRESHOLD)) begin
                            state_d = ST_UNLOCKED;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk40 or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_UNLOCKED;
            run_q      <= '0;
            miss_q     <= '0;
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
            error_q    <= error_d;
        end
    end

    assign error  = error_q;
    assign locked = (state_q == ST_LOCKED);

`ifdef PRBS_ERR_COUNTER_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // Counts alongside the registered pulse; a simultaneous clear takes priority.
    always_comb begin
        count_d = count_q;
        if (clearCount) begin
            count_d = '0;
        end else if (error_d && (count_q != '1)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk40 or negedge RSTn) begin
        if (!RSTn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign errorCount = count_q;
`else
    logic unused_clear_count;
    assign unused_clear_count = clearCount;
    assign errorCount         = '0;
`endif

endmodule

// File: tb/tb_prbs7_word_checker.sv
// Directed bench for prbs7_word_checker: lock, single/burst errors, gaps,
// clear collision, async reset and counter saturation (wide-unlock instance).
module tb_prbs7_word_checker;

    logic        clk40 = 1'b0;
    logic        RSTn;
    logic [31:0] din;
    logic        dinValid;
    logic        clearCount;
    logic        error, locked;
    logic [15:0] errorCount;
    logic        error2, locked2;
    logic [15:0] errorCount2;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [6:0]  gen_st;

`ifdef PRBS_ERR_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk40 = ~clk40;

    prbs7_word_checker dut (
        .clk40      (clk40),
        .RSTn       (RSTn),
        .din        (din),
        .dinValid   (dinValid),
        .clearCount (clearCount),
        .error      (error),
        .locked     (locked),
        .errorCount (errorCount)
    );

    prbs7_word_checker #(.LOCK_THRESHOLD(8), .UNLOCK_THRESHOLD(100000)) dut_wide (
        .clk40      (clk40),
        .RSTn       (RSTn),
        .din        (din),
        .dinValid   (dinValid),
        .clearCount (clearCount),
        .error      (error2),
        .locked     (locked2),
        .errorCount (errorCount2)
    );

    // Serial PRBS7 generator: next bit = b[n-7] ^ b[n-6], s[6] is the oldest bit.
    function automatic logic [31:0] prbs_word(input logic [6:0] st);
        logic [6:0]  s;
        logic        nb;
        logic [31:0] w;
        s = st;
        w = '0;
        for (int k = 31; k >= 0; k--) begin
            nb   = s[6] ^ s[5];
            w[k] = nb;
            s    = {s[5:0], nb};
        end
        return w;
    endfunction

    function automatic logic [15:0] cexp(input logic [15:0] v);
        return CNT_EN ? v : 16'h0000;
    endfunction

    task automatic send(input logic [31:0] w, input logic v, input logic c);
        @(negedge clk40);
        din        = w;
        dinValid   = v;
        clearCount = c;
        @(posedge clk40);
        #1;
        dinValid   = 1'b0;
        clearCount = 1'b0;
    endtask

    task automatic send_good();
        logic [31:0] w;
        w = prbs_word(gen_st);
        send(w, 1'b1, 1'b0);
        gen_st = w[6:0];
    endtask

    task automatic send_bad(input logic c);
        logic [31:0] w;
        w = prbs_word(gen_st) ^ 32'h1;
        send(w, 1'b1, c);
        gen_st = w[6:0];
    endtask

    task automatic test_reset();
        RSTn = 1'b0; din = '0; dinValid = 1'b0; clearCount = 1'b0;
        repeat (3) @(posedge clk40);
        #1;
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (errorCount !== 16'h0) begin n_bad++; $display("FAIL reset_count: got %h want 0000", errorCount); end
        @(negedge clk40);
        RSTn = 1'b1;
    endtask

    task automatic test_lock();
        gen_st = 7'h7F;
        for (int i = 0; i < 9; i++) begin
            send_good();
            n_cmp++; if (locked !== (i == 8)) begin n_bad++; $display("FAIL lock_word%0d: locked got %b want %b", i, locked, (i == 8)); end
            n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL lock_err%0d: got %b want 0", i, error); end
        end
    endtask

    task automatic test_single_error();
        send_bad(1'b0);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL single_err_pulse: got %b want 1", error); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL single_err_locked: got %b want 1", locked); end
        n_cmp++; if (errorCount !== cexp(16'd1)) begin n_bad++; $display("FAIL single_err_count: got %h want %h", errorCount, cexp(16'd1)); end
        send_good();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL single_err_end: got %b want 0", error); end
        n_cmp++; if (errorCount !== cexp(16'd1)) begin n_bad++; $display("FAIL single_err_hold: got %h want %h", errorCount, cexp(16'd1)); end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 5; i++) begin
            send(32'hDEAD_BEEF ^ i, 1'b0, 1'b0);
            n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL gap_err%0d: got %b want 0", i, error); end
            n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL gap_locked%0d: got %b want 1", i, locked); end
        end
        send_good();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL gap_resume_err: got %b want 0", error); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL gap_resume_locked: got %b want 1", locked); end
    endtask

    task automatic test_clear_collision();
        send_bad(1'b1);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL clr_err_pulse: got %b want 1", error); end
        n_cmp++; if (errorCount !== 16'h0) begin n_bad++; $display("FAIL clr_count: got %h want 0000", errorCount); end
        send_good();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL clr_locked: got %b want 1", locked); end
    endtask

    task automatic test_unlock();
        for (int i = 0; i < 4; i++) begin
            send_bad(1'b0);
            n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL unlock_err%0d: got %b want 1", i, error); end
            n_cmp++; if (locked !== (i < 3)) begin n_bad++; $display("FAIL unlock_locked%0d: got %b want %b", i, locked, (i < 3)); end
            n_cmp++; if (errorCount !== cexp(16'(i + 1))) begin n_bad++; $display("FAIL unlock_count%0d: got %h want %h", i, errorCount, cexp(16'(i + 1))); end
        end
        send_bad(1'b0);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL unlocked_no_err: got %b want 0", error); end
        n_cmp++; if (errorCount !== cexp(16'd4)) begin n_bad++; $display("FAIL unlocked_count: got %h want %h", errorCount, cexp(16'd4)); end
    endtask

    task automatic test_reset_midlock();
        for (int i = 0; i < 8; i++) begin
            send_good();
            if (i >= 6) begin
                n_cmp++; if (locked !== (i == 7)) begin n_bad++; $display("FAIL relock%0d: got %b want %b", i, locked, (i == 7)); end
            end
        end
        send_bad(1'b0);
        n_cmp++; if (errorCount !== cexp(16'd5)) begin n_bad++; $display("FAIL pre_rst_count: got %h want %h", errorCount, cexp(16'd5)); end
        #2 RSTn = 1'b0;
        #1;
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL async_rst_locked: got %b want 0", locked); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL async_rst_error: got %b want 0", error); end
        n_cmp++; if (errorCount !== 16'h0) begin n_bad++; $display("FAIL async_rst_count: got %h want 0000", errorCount); end
        @(negedge clk40);
        RSTn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_good();
            if (i >= 7) begin
                n_cmp++; if (locked !== (i == 8)) begin n_bad++; $display("FAIL post_rst_lock%0d: got %b want %b", i, locked, (i == 8)); end
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk40);
        RSTn = 1'b0;
        @(negedge clk40);
        RSTn = 1'b1;
        gen_st = 7'h7F;
        repeat (9) send_good();
        n_cmp++; if (locked2 !== 1'b1) begin n_bad++; $display("FAIL sat_locked: got %b want 1", locked2); end
        send(32'h0, 1'b1, 1'b0);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL zero_first_err: got %b want 1", error); end
        send(32'h0, 1'b1, 1'b0);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL zero_lockup_err: got %b want 1", error); end
        for (int i = 2; i < 65534; i++) send(32'h0, 1'b1, 1'b0);
        n_cmp++; if (errorCount2 !== cexp(16'hFFFE)) begin n_bad++; $display("FAIL sat_preload: got %h want %h", errorCount2, cexp(16'hFFFE)); end
        for (int i = 0; i < 3; i++) begin
            send(32'h0, 1'b1, 1'b0);
            n_cmp++; if (error2 !== 1'b1) begin n_bad++; $display("FAIL sat_err%0d: got %b want 1", i, error2); end
            n_cmp++; if (errorCount2 !== cexp(16'hFFFF)) begin n_bad++; $display("FAIL sat_count%0d: got %h want %h", i, errorCount2, cexp(16'hFFFF)); end
        end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL zero_unlocked: got %b want 0", locked); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL zero_unlocked_err: got %b want 0", error); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_gap();
        test_clear_collision();
        test_unlock();
        test_reset_midlock();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs7_word_checker.md
PRBS7_WORD_CHECKER -- requirements
Module: prbs7_word_checker

Interface
REQ-001 Parameter LOCK_THRESHOLD, default 8: consecutive matching valid words required to enter LOCKED.
REQ-002 Parameter UNLOCK_THRESHOLD, default 4: consecutive mismatching valid words in LOCKED that force UNLOCKED.
REQ-003 clk40  input  1  40 MHz clock; the only clock.
REQ-004 RSTn  input  1  asynchronous, active-low reset.
REQ-005 din  input  32  received word; din[31] is the oldest bit in time.
REQ-006 dinValid  input  1  din qualifier; words with dinValid=0 are ignored.
REQ-007 clearCount  input  1  synchronous clear of errorCount.
REQ-008 error  output  1  one-cycle pulse per mismatching word while LOCKED; feeds the LED error-extend stage.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 errorCount  output  16  saturating count of error pulses.

Function
REQ-011 PRBS7 relation: bit b[n] = b[n-7] XOR b[n-6] across the continuous bitstream, din[31] first.
REQ-012 Predicted word: computed from the last 7 bits (bits [6:0]) of the previous valid word; 32 > 7, so prediction is fully determined.
REQ-013 A history-valid flag is cleared by reset; the first valid word after reset only loads history, with no compare and no match/mismatch.
REQ-014 Every valid word loads history regardless of match (self-synchronising checker).
REQ-015 States: UNLOCKED, LOCKED; reset state is UNLOCKED.
REQ-016 UNLOCKED: match increments the run counter; mismatch clears it; the run counter reaching LOCK_THRESHOLD -> LOCKED, and the counter clears.
REQ-017 LOCKED: mismatch asserts error and increments the miss counter; match clears the miss counter; the miss counter reaching UNLOCK_THRESHOLD -> UNLOCKED.
REQ-018 error is registered: it asserts exactly 1 cycle after the clk40 edge that samples the mismatching valid word, for one cycle.
REQ-019 The mismatch that causes unlock still produces an error pulse; mismatches in UNLOCKED never pulse error.
REQ-020 dinValid=0 cycles hold all counters and state; the error output is 0 in those cycles.
REQ-021 errorCount increments on each error pulse, saturates at 0xFFFF, and never wraps.
REQ-022 When clearCount and an error occur in the same cycle, clearCount wins and errorCount becomes 0.
REQ-023 An all-zero word stream is a mismatch-free lock-up case; it is reported as a mismatch whenever predicted history is all-zero and din is all-zero.
REQ-024 Run and miss counters are sized to hold the threshold values; a threshold value of 0 is illegal.

Reset
REQ-025 RSTn low asynchronously forces: state UNLOCKED, error=0, locked=0, errorCount=0, counters=0, history-valid=0, history=0.
REQ-026 Reset asserted mid-lock drops locked immediately; operation restarts from the first-word rule (REQ-013) after release.

Configuration
REQ-027 Macro PRBS_ERR_COUNTER_EN: when defined, errorCount and clearCount behave as above.
REQ-028 Without PRBS_ERR_COUNTER_EN: errorCount is tied to 0, clearCount is ignored, and no counter flops exist; error and locked behaviour is unchanged.

Structure
REQ-029 The shared package prbs_check_pkg holds the state enum, the word width (32), the count width (16), and the PRBS7 tap constants (7,6).
REQ-030 One sub-module, prbs7_predict: combinational 7-bit history -> 32-bit predicted word; all state stays in prbs7_word_checker.

Verification
REQ-031 Continuous valid PRBS7 stream from seed 7'h7F -> locked rises 1 cycle after the 9th valid word (1 load + 8 matches); error stays 0.
REQ-032 In LOCKED, flip din[0] of one word -> one error pulse 1 cycle later, errorCount=1, locked remains 1.
REQ-033 In LOCKED, 4 consecutive corrupted words -> 4 error pulses, locked falls with the 4th, errorCount=4.
REQ-034 Preload errorCount to 0xFFFE via errors, then inject 3 errors -> errorCount=0xFFFF and holds.
REQ-035 clearCount asserted in the same cycle as an error -> errorCount=0 next cycle; dinValid gaps of 5 cycles mid-stream -> no error and lock retained.
REQ-036 RSTn pulled low while locked -> locked=0 and errorCount=0 without a clock edge; relock requires 9 valid words.
